// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester, the data requester and the shared memory port
// into one interface. ADDR_W and DATA_W must match the arbiter's parameters.
//   Fetch side : i_valid, i_addr -> i_data_ok, i_data (32-bit word)
//   Data side  : d_valid, d_addr, d_size, d_strobe, d_wdata -> d_data_ok, d_rdata
//   Memory side: m_valid, m_addr, m_size, m_strobe, m_wdata -> m_data_ok, m_rdata
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus memory)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  i_valid;
  logic [ADDR_W-1:0]     i_addr;
  logic                  i_data_ok;
  logic [31:0]           i_data;

  logic                  d_valid;
  logic [ADDR_W-1:0]     d_addr;
  logic [2:0]            d_size;
  logic [DATA_W/8-1:0]   d_strobe;
  logic [DATA_W-1:0]     d_wdata;
  logic                  d_data_ok;
  logic [DATA_W-1:0]     d_rdata;

  logic                  m_valid;
  logic [ADDR_W-1:0]     m_addr;
  logic [2:0]            m_size;
  logic [DATA_W/8-1:0]   m_strobe;
  logic [DATA_W-1:0]     m_wdata;
  logic                  m_data_ok;
  logic [DATA_W-1:0]     m_rdata;

  modport slave (
    input  i_valid, i_addr,
    output i_data_ok, i_data,
    input  d_valid, d_addr, d_size, d_strobe, d_wdata,
    output d_data_ok, d_rdata,
    output m_valid, m_addr, m_size, m_strobe, m_wdata,
    input  m_data_ok, m_rdata
  );

  modport master (
    output i_valid, i_addr,
    input  i_data_ok, i_data,
    output d_valid, d_addr, d_size, d_strobe, d_wdata,
    input  d_data_ok, d_rdata,
    input  m_valid, m_addr, m_size, m_strobe, m_wdata,
    output m_data_ok, m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the instruction-fetch bus and the data bus.
// The granted request is latched onto the memory port and held until the
// memory answers; the answer is routed back combinationally to the requester
// that owns the port. Data normally wins over fetch, but once fetch has been
// passed over STARVE_LIMIT times in a row it is granted next.
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   bus_io - fetch/data requester and memory port signals (slave modport)
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus_io
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  state_e                state_q;
  logic                  m_valid_q;
  logic [ADDR_W-1:0]     m_addr_q;
  logic [2:0]            m_size_q;
  logic [DATA_W/8-1:0]   m_strobe_q;
  logic [DATA_W-1:0]     m_wdata_q;
  logic [3:0]            starve_q;

  logic                  grant_d;
  logic                  grant_i;
  logic                  resp_ok;

  // Data wins unless fetch is waiting and has already been passed over
  // STARVE_LIMIT times in a row.
  always_comb begin
    grant_d = bus_io.d_valid && (!bus_io.i_valid || (starve_q < LIMIT));
    grant_i = !grant_d && bus_io.i_valid;
  end

  // Arbitration FSM; the memory-port outputs are registered here so they stay
  // frozen for the whole transaction regardless of requester activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      m_valid_q  <= 1'b0;
      m_addr_q   <= '0;
      m_size_q   <= '0;
      m_strobe_q <= '0;
      m_wdata_q  <= '0;
      starve_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q    <= BUSY_D;
            m_valid_q  <= 1'b1;
            m_addr_q   <= bus_io.d_addr;
            m_size_q   <= bus_io.d_size;
            m_strobe_q <= bus_io.d_strobe;
            m_wdata_q  <= bus_io.d_wdata;
            // Count only grants that made a pending fetch wait.
            if (!bus_io.i_valid) begin
              starve_q <= '0;
            end else if (starve_q != LIMIT) begin
              starve_q <= starve_q + 4'd1;
            end
          end else if (grant_i) begin
            state_q    <= BUSY_I;
            m_valid_q  <= 1'b1;
            m_addr_q   <= bus_io.i_addr;
            m_size_q   <= 3'd2;
            m_strobe_q <= '0;
            m_wdata_q  <= '0;
            starve_q   <= '0;
          end else begin
            // Nothing granted implies fetch is not waiting.
            starve_q <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus_io.m_data_ok) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A response arriving while reset is asserted belongs to an abandoned
  // transaction and must not reach the requester.
  assign resp_ok = bus_io.m_data_ok && !reset;

  assign bus_io.m_valid  = m_valid_q;
  assign bus_io.m_addr   = m_addr_q;
  assign bus_io.m_size   = m_size_q;
  assign bus_io.m_strobe = m_strobe_q;
  assign bus_io.m_wdata  = m_wdata_q;

  assign bus_io.i_data_ok = (state_q == BUSY_I) && resp_ok;
  assign bus_io.d_data_ok = (state_q == BUSY_D) && resp_ok;

  // Fetch words are 32 bits; address bit 2 picks the half of the memory word.
  assign bus_io.i_data  = m_addr_q[2] ? bus_io.m_rdata[63:32] : bus_io.m_rdata[31:0];
  assign bus_io.d_rdata = bus_io.m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter through directed scenarios (fetch, store, held-input
// changes, simultaneous requests, starvation, reset mid-transaction) and then
// a long randomized run, comparing every cycle against a reference model of
// the arbitration rules.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 64;
  localparam int DATA_W       = 64;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_io(bus)
  );

  int testCount = 0;
  int failCount = 0;

  // Reference model: who owns the port, what the port should show, and how
  // many data grants in a row have jumped a waiting fetch.
  int          owner;
  int          dataRun;
  logic        eValid;
  logic [63:0] eAddr;
  logic [2:0]  eSize;
  logic [7:0]  eStrobe;
  logic [63:0] eWdata;
  logic        lastIOk;
  logic        lastDOk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [63:0] ia,
                               input logic dv, input logic [63:0] da,
                               input logic [2:0] ds, input logic [7:0] dst,
                               input logic [63:0] dw, input logic mok,
                               input logic [63:0] mrd);
    bus.i_valid   = iv;
    bus.i_addr    = ia;
    bus.d_valid   = dv;
    bus.d_addr    = da;
    bus.d_size    = ds;
    bus.d_strobe  = dst;
    bus.d_wdata   = dw;
    bus.m_data_ok = mok;
    bus.m_rdata   = mrd;
  endtask

  // Called at a falling edge with inputs already driven: compares the DUT to
  // the model, advances the model across the rising edge, returns at the
  // next falling edge.
  task automatic stepCycle();
    logic expI;
    logic expD;
    logic fetchDue;
    logic [63:0] word;
    #1;
    checkOutput("m_valid", 64'(bus.m_valid), 64'(eValid));
    checkOutput("m_addr", bus.m_addr, eAddr);
    checkOutput("m_size", 64'(bus.m_size), 64'(eSize));
    checkOutput("m_strobe", 64'(bus.m_strobe), 64'(eStrobe));
    checkOutput("m_wdata", bus.m_wdata, eWdata);
    expI = !reset && (owner == 1) && bus.m_data_ok;
    expD = !reset && (owner == 2) && bus.m_data_ok;
    checkOutput("i_data_ok", 64'(bus.i_data_ok), 64'(expI));
    checkOutput("d_data_ok", 64'(bus.d_data_ok), 64'(expD));
    if (expI) begin
      word = bus.m_rdata;
      checkOutput("i_data", 64'(bus.i_data), eAddr[2] ? {32'h0, word[63:32]} : {32'h0, word[31:0]});
    end
    if (expD) checkOutput("d_rdata", bus.d_rdata, bus.m_rdata);
    lastIOk = expI;
    lastDOk = expD;

    if (reset) begin
      owner = 0; dataRun = 0; eValid = 0;
      eAddr = 0; eSize = 0; eStrobe = 0; eWdata = 0;
    end else if (owner != 0) begin
      if (bus.m_data_ok) begin
        owner = 0;
        eValid = 0;
      end
    end else begin
      fetchDue = bus.i_valid && (!bus.d_valid || dataRun == STARVE_LIMIT);
      if (bus.d_valid && !fetchDue) begin
        owner = 2; eValid = 1;
        eAddr = bus.d_addr; eSize = bus.d_size;
        eStrobe = bus.d_strobe; eWdata = bus.d_wdata;
        dataRun = bus.i_valid ? ((dataRun < STARVE_LIMIT) ? dataRun + 1 : STARVE_LIMIT) : 0;
      end else if (bus.i_valid) begin
        owner = 1; eValid = 1;
        eAddr = bus.i_addr; eSize = 3'd2; eStrobe = 8'h0; eWdata = 64'h0;
        dataRun = 0;
      end else begin
        dataRun = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic        iPend, dPend;
    logic [63:0] iA, dA, dW;
    logic [2:0]  dS;
    logic [7:0]  dSt;
    logic        mOk;
    logic [63:0] rd;
    int          grants;
    logic        isData [10];

    owner = 0; dataRun = 0; eValid = 0;
    eAddr = 0; eSize = 0; eStrobe = 0; eWdata = 0;
    lastIOk = 0; lastDOk = 0;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // Reset state
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    checkOutput("reset m_valid", 64'(bus.m_valid), 64'h0);
    checkOutput("reset m_addr", bus.m_addr, 64'h0);

    // Fetch only, memory answers three cycles after the grant
    applyStimulus(1, 64'h8000_0004, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    checkOutput("fetch m_size", 64'(bus.m_size), 64'd2);
    checkOutput("fetch m_strobe", 64'(bus.m_strobe), 64'h0);
    stepCycle();
    applyStimulus(1, 64'h8000_0004, 0, 0, 0, 0, 0, 1, 64'h1111_2222_3333_4444);
    #1;
    checkOutput("fetch i_data", 64'(bus.i_data), 64'h1111_2222);
    checkOutput("fetch i_data_ok", 64'(bus.i_data_ok), 64'h1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("fetch ok one cycle", 64'(bus.i_data_ok), 64'h0);
    stepCycle();

    // Store only, with the requester changing its address mid-transaction
    applyStimulus(0, 0, 1, 64'h8000_0100, 3, 8'hFF, 64'hDEAD_BEEF_0000_0001, 0, 0);
    stepCycle();
    checkOutput("store m_addr", bus.m_addr, 64'h8000_0100);
    checkOutput("store m_strobe", 64'(bus.m_strobe), 64'hFF);
    checkOutput("store m_wdata", bus.m_wdata, 64'hDEAD_BEEF_0000_0001);
    stepCycle();
    applyStimulus(0, 0, 1, 64'h8000_0200, 3, 8'hFF, 64'hDEAD_BEEF_0000_0001, 0, 0);
    stepCycle();
    checkOutput("held m_addr", bus.m_addr, 64'h8000_0100);
    applyStimulus(0, 0, 1, 64'h8000_0200, 3, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1, 64'h55);
    #1;
    checkOutput("store d_data_ok", 64'(bus.d_data_ok), 64'h1);
    checkOutput("store i_data_ok", 64'(bus.i_data_ok), 64'h0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Simultaneous requests: data first, then fetch once data drops
    applyStimulus(1, 64'h0000_1000, 1, 64'h0000_2000, 2, 8'h0, 0, 0, 0);
    stepCycle();
    checkOutput("simul first data", bus.m_addr, 64'h0000_2000);
    applyStimulus(1, 64'h0000_1000, 1, 64'h0000_2000, 2, 8'h0, 0, 1, 64'h77);
    stepCycle();
    applyStimulus(1, 64'h0000_1000, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    checkOutput("simul then fetch", bus.m_addr, 64'h0000_1000);
    applyStimulus(1, 64'h0000_1000, 0, 0, 0, 0, 0, 1, 64'h88);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Starvation: both requesters held high, memory answers at once
    grants = 0;
    for (int c = 0; c < 80 && grants < 10; c++) begin
      mOk = bus.m_valid;
      if (mOk) begin
        isData[grants] = (bus.m_addr == 64'h0000_2000);
        grants++;
      end
      applyStimulus(1, 64'h0000_1000, 1, 64'h0000_2000, 3, 8'h0F, 64'h1234, mOk, 64'h99);
      stepCycle();
    end
    checkOutput("starve grant count", 64'(grants), 64'd10);
    for (int g = 0; g < grants; g++) begin
      checkOutput($sformatf("starve grant %0d", g), 64'(isData[g]),
                  ((g % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 64'h0 : 64'h1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();

    // Reset while a fetch is in flight; late memory answer is ignored
    applyStimulus(1, 64'h0000_3008, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    stepCycle();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 64'hABCD);
    #1;
    checkOutput("post-reset m_valid", 64'(bus.m_valid), 64'h0);
    checkOutput("post-reset i_data_ok", 64'(bus.i_data_ok), 64'h0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Randomized traffic against the model
    iPend = 0; dPend = 0; iA = 0; dA = 0; dW = 0; dS = 0; dSt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (lastIOk) iPend = 0;
      if (lastDOk) dPend = 0;
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        iPend = 0;
        dPend = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        reset = 1'b0;
        if (!iPend && $urandom_range(0, 9) < 4) begin
          iPend = 1;
          iA = {$urandom, $urandom} & ~64'h3;
        end
        if (!dPend && $urandom_range(0, 9) < 4) begin
          dPend = 1;
          dA  = {$urandom, $urandom};
          dS  = 3'($urandom_range(0, 3));
          dSt = 8'($urandom);
          dW  = {$urandom, $urandom};
        end
        if (owner != 0) mOk = ($urandom_range(0, 9) < 4);
        else mOk = ($urandom_range(0, 9) == 0);
        rd = {$urandom, $urandom};
        applyStimulus(iPend, iPend ? iA : 64'h0, dPend, dPend ? dA : 64'h0,
                      dS, dSt, dW, mOk, rd);
      end
      stepCycle();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one memory port between the core's instruction-fetch bus and its data bus. It sits between the core's fetch/load-store interfaces and the single-ported memory/bus bridge. It latches the granted request, holds it stable on the memory port until the memory responds, and routes the response back to the granted requester. Fixed data-over-fetch priority, with a starvation counter that forces a fetch grant after a bounded run of data grants.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, memory data width; fetch words are 32 bits
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch is pending; range 1..15
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_valid  in  1  fetch request
- i_addr  in  ADDR_W  fetch address, 4-byte aligned
- i_data_ok  out  1  fetch response strobe
- i_data  out  32  fetch instruction word
- d_valid  in  1  data request
- d_addr  in  ADDR_W  data address
- d_size  in  3  access size code (0=B, 1=H, 2=W, 3=D)
- d_strobe  in  DATA_W/8  byte write enables; all-zero means read
- d_wdata  in  DATA_W  store data
- d_data_ok  out  1  data response strobe
- d_rdata  out  DATA_W  load data
- m_valid  out  1  memory request
- m_addr  out  ADDR_W  latched address
- m_size  out  3  latched size; fetch always 2
- m_strobe  out  DATA_W/8  latched strobe; fetch always 0
- m_wdata  out  DATA_W  latched store data; fetch 0
- m_data_ok  in  1  memory response strobe, single cycle
- m_rdata  in  DATA_W  memory read data, valid with m_data_ok

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: if d_valid and (not i_valid or starve_cnt < STARVE_LIMIT) -> BUSY_D. Else if i_valid -> BUSY_I. Else stay.
- On the grant edge, latch the granted request's addr/size/strobe/wdata into the m_* registers and set m_valid=1.
- BUSY_x: m_* held constant. On m_data_ok, clear m_valid at the edge and return to IDLE.
- Response routing, combinational in the m_data_ok cycle:
  - BUSY_I: i_data_ok=1, i_data = m_addr[2] ? m_rdata[63:32] : m_rdata[31:0].
  - BUSY_D: d_data_ok=1, d_rdata=m_rdata.
  - Non-granted *_data_ok stays 0. Outside BUSY, both *_data_ok are 0.
- starve_cnt (4-bit):
  - Increments on each data grant made while i_valid=1.
  - Clears on any fetch grant, and whenever i_valid=0 in IDLE.
  - Saturates at STARVE_LIMIT.
- Requesters hold valid and payload until their data_ok. The arbiter ignores requester input changes while BUSY.
- m_data_ok in IDLE is ignored: no state change, no response strobe.

## Timing
- Reset values: state IDLE, m_valid 0, m_addr/m_size/m_strobe/m_wdata 0, starve_cnt 0. i_data_ok and d_data_ok are 0 because state is IDLE.
- Request latency: valid sampled in IDLE at edge N -> m_valid=1 from cycle N+1.
- Response latency: zero cycles from m_data_ok to requester data_ok, same cycle.
- After m_data_ok the FSM spends at least one cycle in IDLE. Minimum spacing between grants is therefore two cycles.
  - This lets a requester drop valid after its data_ok without being re-granted.
- Simultaneous i_valid and d_valid in IDLE: data wins unless starve_cnt == STARVE_LIMIT.
- Reset mid-transaction: the in-flight request is abandoned, m_valid drops at the reset edge, and no data_ok is issued. The memory side is reset in the same cycle.

## Test plan
- Fetch only: i_valid=1, i_addr=0x8000_0004; memory returns m_rdata=0x1111_2222_3333_4444 three cycles later -> m_size=2, m_strobe=0, i_data=0x1111_2222 in the m_data_ok cycle, i_data_ok for exactly one cycle.
- Store only: d_addr=0x8000_0100, d_strobe=0xFF, d_wdata=0xDEAD_BEEF_0000_0001 -> m_* match from the cycle after the request; d_data_ok coincides with m_data_ok; i_data_ok stays 0.
- Simultaneous requests with starve_cnt=0 -> BUSY_D first. The fetch is granted on the first IDLE cycle after the data response, provided d_valid has dropped.
- Starvation: d_valid and i_valid held high continuously, STARVE_LIMIT=4 -> four data grants, then a fetch grant, then starve_cnt returns to 0.
- Input change while BUSY: d_addr changes from 0x100 to 0x200 mid-transaction -> m_addr stays 0x100 until m_data_ok.
- Reset asserted while BUSY_I -> next cycle m_valid=0, state IDLE, no i_data_ok even if m_data_ok arrives one cycle later.
